rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter that shares the register file's single write port between three requesters: the ALU pipe (0), the load/store unit (1) and the multiply/divide unit (2). It accepts valid/grant handshakes, picks one non-$0 write per cycle by round-robin, and registers the winner onto the RF write port (A3/WD/PC/RFWr). Writes to $0 are acknowledged and discarded without using the port. It sits between the execute/memory stages and RF, and drives the pipeline stall signal whenever a write-back request is waiting.

## Interface
- NREQ, 3, number of requesters; fixed, index 0 = ALU, 1 = LSU, 2 = MDU
- PTR_RST, 0, round-robin pointer value after reset (0..2)
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- Req  in  3  bit i: requester i has a write pending
- A3_i (i=0..2)  in  5  destination register of requester i
- WD_i (i=0..2)  in  32  write data of requester i
- PC_i (i=0..2)  in  32  PC of the instruction producing the write
- Gnt  out  3  bit i: request i accepted this cycle (combinational)
- A3  out  5  registered RF write address
- WD  out  32  registered RF write data
- PC  out  32  registered PC, used by RF for the write trace
- RFWr  out  1  registered RF write enable
- Stall  out  1  high when some Req bit is high and its Gnt bit is low
- Ptr  out  2  current round-robin pointer, for debug

## Operation
- Zero filter: a request with Req[i]=1 and A3_i=0 always gets Gnt[i]=1 in the same cycle. It never wins arbitration and never moves Ptr. Any number of $0 requests can be granted together.
- Eligible set: E[i] = Req[i] & (A3_i != 0).
- Arbitration: scan indices Ptr, Ptr+1, Ptr+2 (mod 3). The first index with E set is the winner w, and Gnt[w]=1. Every other eligible request gets Gnt=0.
- On a grant to w, at the next edge:
  - A3 <= A3_w, WD <= WD_w, PC <= PC_w, RFWr <= 1
  - Ptr <= (w+1) mod 3
- No eligible request: RFWr <= 0. A3, WD and PC hold their values. Ptr holds.
- Handshake rules:
  - A requester holds Req, A3, WD and PC stable until the cycle in which its Gnt is high.
  - It may drop Req or present a new write in the cycle after Gnt.
  - The arbiter samples inputs only in the granting cycle.
- Fairness: with all three requesting continuously, grants rotate 0,1,2,0,… from Ptr. A waiting requester is granted within 3 cycles of raising Req.
- Ordering: each requester's writes reach RF in the order they are granted. The issue logic guarantees that two requesters never target the same register with both requests outstanding. The arbiter does not check for this.
- Stall = |(Req & ~Gnt).
- Ptr encoding: only values 0..2 are legal. If Ptr is ever 3, it is treated as 0 and the next grant reloads it normally.

## Timing
- Reset asserted (Reset=0) takes effect immediately, regardless of Clk:
  - RFWr=0, A3=0, WD=0, PC=0, Ptr=PTR_RST
  - Gnt and Stall stay combinational and reflect the inputs.
- The first grant can occur in the cycle after Reset deasserts.
- Reset asserted mid-operation discards the registered write that has not yet been clocked into RF: RFWr drops asynchronously. Requesters see Gnt only combinationally, so no in-flight state needs recovery.
- Latency:
  - Gnt is in the same cycle as Req.
  - RFWr/A3/WD/PC are valid in the cycle after the grant, and RF captures them at the following edge.
  - Total from Req to register updated: 2 edges.
- Throughput: one RF write per cycle. With continuous requests, RFWr stays high back-to-back.
- Simultaneous events:
  - A $0 request and a non-$0 request in the same cycle both get Gnt.
  - A new Req arriving in the same cycle a grant goes to another requester is arbitrated against the updated Ptr in the next cycle.
- The critical path is Req/A3_i → Gnt → output-register mux. All outputs except Gnt and Stall come straight from flops.

## Test plan
- Reset: hold Reset=0 for 3 cycles with Req=3'b111 → RFWr=0, A3=0, WD=0, PC=0, Ptr=0 throughout. Pulse Reset=0 mid-burst → RFWr falls before the next Clk edge.
- Single requester: Req=3'b010, A3_1=5, WD_1=32'h1234_5678, PC_1=32'h3000 → Gnt=3'b010 the same cycle. Next cycle: RFWr=1, A3=5, WD=32'h1234_5678, PC=32'h3000, Ptr=2.
- Round-robin: Ptr=0, Req=3'b111 held for 6 cycles, A3_i=i+1 → grants 0,1,2,0,1,2. A3 sequence 1,2,3,1,2,3 with RFWr continuously 1. Stall=1 every cycle.
- $0 filter: Req=3'b101, A3_0=0, A3_2=7 → Gnt=3'b101 in one cycle. Next cycle: A3=7, RFWr=1, and Ptr=0 (advanced past 2, not by the $0 grant). Req=3'b001 with A3_0=0 alone → RFWr=0 next cycle, Ptr unchanged.
- Hold stability: Req=3'b011 with Ptr=1 → requester 1 granted first. Requester 0 keeps A3_0=9 and WD_0=32'hdead_beef held and is granted the next cycle. RF write sees WD=32'hdead_beef.
- Idle gap: a grant followed by Req=0 → RFWr=1 for exactly one cycle, then 0. A3/WD/PC keep their last values and Ptr holds.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: three requesters share one RF write
// port by round-robin; $0 writes are acknowledged and dropped.
module rf_wb_arbiter #(
    parameter int         NREQ    = 3,
    parameter logic [1:0] PTR_RST = 2'd0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NREQ-1:0] Req,
    input  logic [4:0]      A3_0,
    input  logic [4:0]      A3_1,
    input  logic [4:0]      A3_2,
    input  logic [31:0]     WD_0,
    input  logic [31:0]     WD_1,
    input  logic [31:0]     WD_2,
    input  logic [31:0]     PC_0,
    input  logic [31:0]     PC_1,
    input  logic [31:0]     PC_2,
    output logic [NREQ-1:0] Gnt,
    output logic [4:0]      A3,
    output logic [31:0]     WD,
    output logic [31:0]     PC,
    output logic            RFWr,
    output logic            Stall,
    output logic [1:0]      Ptr
);

    logic [2:0]  zero;
    logic [2:0]  elig;
    logic [2:0]  win_oh;
    logic [1:0]  ptr_eff;
    logic [4:0]  nxt_a3;
    logic [31:0] nxt_wd;
    logic [31:0] nxt_pc;
    logic [1:0]  nxt_ptr;

    assign zero    = {A3_2 == 5'd0, A3_1 == 5'd0, A3_0 == 5'd0};
    assign elig    = Req & ~zero;
    assign ptr_eff = (Ptr == 2'd3) ? 2'd0 : Ptr;

    // Round-robin pick: first eligible index scanning from the pointer.
    always_comb begin
        win_oh = 3'b000;
        case (ptr_eff)
            2'd1: begin
                if (elig[1])      win_oh = 3'b010;
                else if (elig[2]) win_oh = 3'b100;
                else if (elig[0]) win_oh = 3'b001;
            end
            2'd2: begin
                if (elig[2])      win_oh = 3'b100;
                else if (elig[0]) win_oh = 3'b001;
                else if (elig[1]) win_oh = 3'b010;
            end
            default: begin
                if (elig[0])      win_oh = 3'b001;
                else if (elig[1]) win_oh = 3'b010;
                else if (elig[2]) win_oh = 3'b100;
            end
        endcase
    end

    assign Gnt   = (Req & zero) | win_oh;
    assign Stall = |(Req & ~Gnt);

    // Select the winner's write and the pointer slot after it.
    always_comb begin
        nxt_a3  = A3;
        nxt_wd  = WD;
        nxt_pc  = PC;
        nxt_ptr = Ptr;
        unique case (1'b1)
            win_oh[0]: begin
                nxt_a3  = A3_0;
                nxt_wd  = WD_0;
                nxt_pc  = PC_0;
                nxt_ptr = 2'd1;
            end
            win_oh[1]: begin
                nxt_a3  = A3_1;
                nxt_wd  = WD_1;
                nxt_pc  = PC_1;
                nxt_ptr = 2'd2;
            end
            win_oh[2]: begin
                nxt_a3  = A3_2;
                nxt_wd  = WD_2;
                nxt_pc  = PC_2;
                nxt_ptr = 2'd0;
            end
            default: begin
                nxt_a3  = A3;
                nxt_wd  = WD;
                nxt_pc  = PC;
                nxt_ptr = Ptr;
            end
        endcase
    end

    // RF write port register; reset drops any pending write at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            RFWr <= 1'b0;
            A3   <= 5'd0;
            WD   <= 32'd0;
            PC   <= 32'd0;
            Ptr  <= PTR_RST;
        end else begin
            RFWr <= |win_oh;
            A3   <= nxt_a3;
            WD   <= nxt_wd;
            PC   <= nxt_pc;
            Ptr  <= nxt_ptr;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios then randomized requesters
// checked against a round-robin reference model.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [4:0]  a3 [3];
    logic [31:0] wd [3];
    logic [31:0] pc [3];
    logic [2:0]  Gnt;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC;
    logic        RFWr;
    logic        Stall;
    logic [1:0]  Ptr;

    int errors = 0;
    int checks = 0;

    int          mptr;
    logic        m_wr;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;
    logic [2:0]  egnt;
    int          ewin;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NREQ(3), .PTR_RST(2'd0)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .Req   (req),
        .A3_0  (a3[0]),
        .A3_1  (a3[1]),
        .A3_2  (a3[2]),
        .WD_0  (wd[0]),
        .WD_1  (wd[1]),
        .WD_2  (wd[2]),
        .PC_0  (pc[0]),
        .PC_1  (pc[1]),
        .PC_2  (pc[2]),
        .Gnt   (Gnt),
        .A3    (A3),
        .WD    (WD),
        .PC    (PC),
        .RFWr  (RFWr),
        .Stall (Stall),
        .Ptr   (Ptr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mptr = 0;
        m_wr = 1'b0;
        m_a3 = 5'd0;
        m_wd = 32'd0;
        m_pc = 32'd0;
    endtask

    // Expected grants from the current inputs and model pointer.
    task automatic predict();
        int idx;
        ewin = -1;
        egnt = 3'b000;
        for (int k = 0; k < 3; k++) begin
            idx = (mptr + k) % 3;
            if (ewin < 0 && req[idx] && a3[idx] != 5'd0) ewin = idx;
        end
        for (int i = 0; i < 3; i++)
            if (req[i] && a3[i] == 5'd0) egnt[i] = 1'b1;
        if (ewin >= 0) egnt[ewin] = 1'b1;
    endtask

    // One clock: check at negedge, advance model at posedge.
    task automatic cycle();
        @(negedge clk);
        predict();
        check("gnt", {29'd0, Gnt}, {29'd0, egnt});
        check("stall", {31'd0, Stall}, {31'd0, |(req & ~egnt)});
        check("rfwr", {31'd0, RFWr}, {31'd0, m_wr});
        check("a3", {27'd0, A3}, {27'd0, m_a3});
        check("wd", WD, m_wd);
        check("pc", PC, m_pc);
        check("ptr", {30'd0, Ptr}, mptr);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (ewin >= 0) begin
            m_wr = 1'b1;
            m_a3 = a3[ewin];
            m_wd = wd[ewin];
            m_pc = pc[ewin];
            mptr = (ewin + 1) % 3;
        end else begin
            m_wr = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b111;
        for (int i = 0; i < 3; i++) begin
            a3[i] = 5'(i + 1);
            wd[i] = 32'h100 + i;
            pc[i] = 32'h200 + i;
        end
        model_reset();
        egnt = 3'b000;
        ewin = -1;

        // Reset held with all requests up
        for (int n = 0; n < 3; n++) cycle();
        check("rst_rfwr", {31'd0, RFWr}, 32'd0);

        // Single requester
        req   = 3'b010;
        a3[1] = 5'd5;
        wd[1] = 32'h1234_5678;
        pc[1] = 32'h3000;
        rst_n = 1'b1;
        cycle();
        check("single_gnt", {29'd0, Gnt}, 32'b010);
        check("single_a3", {27'd0, A3}, 32'd5);
        check("single_wd", WD, 32'h1234_5678);
        check("single_pc", PC, 32'h3000);
        check("single_ptr", {30'd0, Ptr}, 32'd2);
        check("single_wr", {31'd0, RFWr}, 32'd1);

        // Move pointer back to 0
        req   = 3'b100;
        a3[2] = 5'd3;
        cycle();
        check("ptr0", {30'd0, Ptr}, 32'd0);

        // Round-robin with all three
        req = 3'b111;
        for (int i = 0; i < 3; i++) a3[i] = 5'(i + 1);
        for (int k = 0; k < 6; k++) begin
            cycle();
            check("rr_a3", {27'd0, A3}, k % 3 + 1);
            check("rr_wr", {31'd0, RFWr}, 32'd1);
        end

        // $0 filter
        req   = 3'b101;
        a3[0] = 5'd0;
        a3[2] = 5'd7;
        cycle();
        check("z_a3", {27'd0, A3}, 32'd7);
        check("z_ptr", {30'd0, Ptr}, 32'd0);
        req = 3'b001;
        cycle();
        check("z_only_wr", {31'd0, RFWr}, 32'd0);
        check("z_only_ptr", {30'd0, Ptr}, 32'd0);

        // Hold stability with pointer at 1
        req   = 3'b001;
        a3[0] = 5'd4;
        cycle();
        check("h_ptr", {30'd0, Ptr}, 32'd1);
        req   = 3'b011;
        a3[0] = 5'd9;
        wd[0] = 32'hdead_beef;
        a3[1] = 5'd6;
        cycle();
        check("h_first", {27'd0, A3}, 32'd6);
        req = 3'b001;
        cycle();
        check("h_a3", {27'd0, A3}, 32'd9);
        check("h_wd", WD, 32'hdead_beef);

        // Idle gap
        req = 3'b000;
        cycle();
        check("idle_wr", {31'd0, RFWr}, 32'd0);
        check("idle_a3", {27'd0, A3}, 32'd9);
        check("idle_ptr", {30'd0, Ptr}, 32'd1);
        cycle();

        // Reset pulse mid-burst
        req = 3'b111;
        for (int i = 0; i < 3; i++) a3[i] = 5'(i + 1);
        cycle();
        check("burst_wr", {31'd0, RFWr}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_wr", {31'd0, RFWr}, 32'd0);
        check("async_a3", {27'd0, A3}, 32'd0);
        check("async_ptr", {30'd0, Ptr}, 32'd0);
        model_reset();
        cycle();
        rst_n = 1'b1;

        // Randomized requesters obeying the hold-until-grant rule
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (req[i] && egnt[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) != 0) begin
                    req[i] = 1'b1;
                    if ($urandom_range(0, 5) == 0) a3[i] = 5'd0;
                    else a3[i] = 5'($urandom_range(1, 31));
                    wd[i] = $urandom;
                    pc[i] = $urandom;
                end
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
